// File: rtl/snn_pkg.sv
// Shared types and helpers for the reward-modulated spiking layer.
package snn_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } snn_state_t;

  function automatic int wgt_max(input int unsigned wgt_w);
    return (1 << (int'(wgt_w) - 1)) - 1;
  endfunction

  function automatic int wgt_min(input int unsigned wgt_w);
    return -(1 << (int'(wgt_w) - 1));
  endfunction

  // Positive shift amounts scale up, negative ones floor-divide; result clamped to acc_w bits
  function automatic logic [63:0] snn_shift(input logic [63:0] val, input int sh,
                                            input int unsigned acc_w);
    logic [63:0] lim;
    logic [63:0] res;
    lim = (64'd1 << acc_w) - 64'd1;
    if (sh >= 0) begin
      if (sh >= 64 || (val >> (64 - sh)) != '0) res = '1;
      else res = val << sh;
    end else begin
      res = val >> (-sh);
    end
    if (res > lim) res = lim;
    return res;
  endfunction

endpackage

// File: rtl/snn_reward_layer_neuron.sv
// One threshold neuron: weight bank, saturating sum, spike flag and reward update.
// SNN_LEAK_EN adds a halving potential that is cleared on each fire.
module snn_neuron
  import snn_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int IN_W   = 4,
  parameter int WGT_W  = 4,
  parameter int ACC_W  = 12,
  parameter int THRESH = 1,
  parameter int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WGT_W-1:0]       wr_data,
  input  logic                   reward_en,
  input  logic                   reward_sign,
  input  logic [N_IN*IN_W-1:0]   in_spk,
  output logic [ACC_W-1:0]       value,
  output logic                   spike
);

  localparam int SUM_W = ACC_W + $clog2(N_IN + 1);
  localparam logic [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic signed [WGT_W-1:0] W_MAX = WGT_W'(wgt_max(WGT_W));
  localparam logic signed [WGT_W-1:0] W_MIN = WGT_W'(wgt_min(WGT_W));
  localparam logic [WGT_W-1:0] W_ONE = WGT_W'(1);
  localparam logic [ACC_W-1:0] TH = ACC_W'(THRESH);

  logic signed [WGT_W-1:0] w [N_IN];
  logic [N_IN-1:0]  in_nz;
  logic [N_IN-1:0]  in_q;
  logic [SUM_W-1:0] sum_wide;
  logic [ACC_W-1:0] sum;
  logic [63:0]      term;
  logic             fire;

  always_comb begin
    sum_wide = '0;
    term     = '0;
    in_nz    = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      term     = snn_shift(64'(in_spk[i*IN_W +: IN_W]), int'(w[i]), ACC_W);
      sum_wide = sum_wide + SUM_W'(term);
      in_nz[i] = |in_spk[i*IN_W +: IN_W];
    end
    sum = (sum_wide > SUM_MAX) ? '1 : sum_wide[ACC_W-1:0];
  end

`ifdef SNN_LEAK_EN
  logic [ACC_W-1:0] pot;
  logic [ACC_W:0]   pot_wide;

  always_comb begin
    pot_wide = {1'b0, pot >> 1} + {1'b0, sum};
    value    = pot_wide[ACC_W] ? '1 : pot_wide[ACC_W-1:0];
  end
`else
  always_comb value = sum;
`endif

  always_comb fire = (value > TH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w     <= '{default: '0};
      in_q  <= '0;
      spike <= 1'b0;
`ifdef SNN_LEAK_EN
      pot   <= '0;
`endif
    end else begin
      if (wr_en) begin
        w[wr_idx] <= wr_data;
      end else if (reward_en) begin
        // Eligibility is last cycle's inputs paired with last cycle's fire flag
        for (int unsigned i = 0; i < N_IN; i++) begin
          if (in_q[i] && spike) begin
            if (!reward_sign && w[i] != W_MAX) w[i] <= w[i] + W_ONE;
            else if (reward_sign && w[i] != W_MIN) w[i] <= w[i] - W_ONE;
          end
        end
      end
      if (run) begin
        spike <= fire;
        in_q  <= in_nz;
`ifdef SNN_LEAK_EN
        pot   <= fire ? '0 : value;
`endif
      end else begin
        spike <= 1'b0;
        in_q  <= '0;
`ifdef SNN_LEAK_EN
        pot   <= '0;
`endif
      end
    end
  end

endmodule

// File: rtl/snn_reward_layer.sv
// Reward-modulated spiking layer: weight load FSM, neuron array and argmax.
// Build option SNN_LEAK_EN enables leaky potentials inside each neuron.
module snn_reward_layer
  import snn_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int IN_W   = 4,
  parameter int WGT_W  = 4,
  parameter int ACC_W  = 12,
  parameter int THRESH = 1,
  parameter int ADDR_W = $clog2(N_IN*N_OUT),
  localparam int PRED_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_mode,
  input  logic [N_IN*IN_W-1:0] in_spk,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [WGT_W-1:0]     mem_data,
  input  logic                 reward_valid,
  input  logic                 reward_sign,
  output logic [N_OUT-1:0]     spike,
  output logic [PRED_W-1:0]    prediction,
  output logic                 ready
);

  localparam int K     = N_IN * N_OUT;
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(K - 1);

  snn_state_t state, state_nxt;

  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_last;
  logic              run;
  logic              load_wr;
  logic              reward_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [ACC_W-1:0]  value [N_OUT];
  logic [ACC_W-1:0]  best_val;
  logic [PRED_W-1:0] best_idx;

  always_comb begin
    cap_last  = cap_valid && (cap_addr == LAST);
    run       = (state == S_RUN) && !write_mode;
    load_wr   = (state == S_LOAD) && !write_mode && cap_valid;
    reward_en = run && reward_valid;
    ready     = (state == S_RUN);
    wr_idx    = IDX_W'(int'(cap_addr) % N_IN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (write_mode) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_LOAD;
        S_LOAD:  if (cap_last) state_nxt = S_RUN;
        S_RUN:   state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Memory returns data one cycle late, so the write address trails mem_addr by one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      cap_valid <= 1'b0;
      cap_addr  <= '0;
    end else if (write_mode || state != S_LOAD) begin
      mem_addr  <= '0;
      cap_valid <= 1'b0;
      cap_addr  <= '0;
    end else begin
      cap_valid <= 1'b1;
      cap_addr  <= mem_addr;
      if (mem_addr != LAST) mem_addr <= mem_addr + 1'b1;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
    logic wr_sel;

    always_comb wr_sel = load_wr && ((int'(cap_addr) / N_IN) == j);

    snn_neuron #(
      .N_IN   (N_IN),
      .IN_W   (IN_W),
      .WGT_W  (WGT_W),
      .ACC_W  (ACC_W),
      .THRESH (THRESH)
    ) u_neuron (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .wr_en       (wr_sel),
      .wr_idx      (wr_idx),
      .wr_data     (mem_data),
      .reward_en   (reward_en),
      .reward_sign (reward_sign),
      .in_spk      (in_spk),
      .value       (value[j]),
      .spike       (spike[j])
    );
  end

  always_comb begin
    best_val = value[0];
    best_idx = '0;
    for (int unsigned j = 1; j < N_OUT; j++) begin
      if (value[j] > best_val) begin
        best_val = value[j];
        best_idx = PRED_W'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      prediction <= '0;
    else if (run) prediction <= best_idx;
    else          prediction <= '0;
  end

endmodule

// File: tb/tb_snn_reward_layer.sv
// Self-checking bench for snn_reward_layer: vector table, corner sequences, randomized model run.
module tb_snn_reward_layer;

  localparam int N_IN = 4, N_OUT = 2, IN_W = 4, WGT_W = 4, ACC_W = 12, THRESH = 1;
  localparam int K = N_IN * N_OUT;
  localparam int ACC_MAX = 4095;

  logic        clk = 1'b0;
  logic        rst, write_mode, reward_valid, reward_sign;
  logic [15:0] in_spk;
  logic [2:0]  mem_addr;
  logic [3:0]  mem_data;
  logic [1:0]  spike;
  logic [0:0]  prediction;
  logic        ready;

  logic [3:0] mem_arr [K];
  int n_tests = 0;
  int n_fail  = 0;

  int wm [N_OUT][N_IN];
  int pm [N_OUT];
  logic [N_IN-1:0]  prev_nz;
  logic [N_OUT-1:0] prev_sp;

  typedef struct {
    int          w0;
    int          w1;
    logic [15:0] in_v;
    logic [1:0]  sp;
    int          pred;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;
  always @(posedge clk) mem_data <= mem_arr[mem_addr];

  snn_reward_layer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .IN_W(IN_W), .WGT_W(WGT_W), .ACC_W(ACC_W), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst(rst), .write_mode(write_mode), .in_spk(in_spk),
    .mem_addr(mem_addr), .mem_data(mem_data), .reward_valid(reward_valid),
    .reward_sign(reward_sign), .spike(spike), .prediction(prediction), .ready(ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int term(input int v, input int w);
    if (w >= 0) return v * (2 ** w);
    return v / (2 ** (-w));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < K; k++) wm[k / N_IN][k % N_IN] = int'($signed(mem_arr[k]));
    for (int j = 0; j < N_OUT; j++) pm[j] = 0;
    prev_nz = '0;
    prev_sp = '0;
  endtask

  task automatic set_uniform(input int w0, input int w1);
    for (int i = 0; i < N_IN; i++) begin
      mem_arr[i]        = 4'(w0);
      mem_arr[N_IN + i] = 4'(w1);
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!ready && cyc < 40);
  endtask

  task automatic reload();
    int c;
    write_mode = 1'b1;
    @(posedge clk); #1;
    check("ready_drop", ready, 0);
    check("addr_restart", mem_addr, 0);
    write_mode = 1'b0;
    wait_ready(c);
    check("reload_latency", c, K + 2);
    model_reset();
  endtask

  // One RUN cycle: the model evaluates with current weights, then applies the reward
  task automatic step(input logic [15:0] in_v, input logic rv, input logic rs);
    int s, best, ep;
    int v [N_OUT];
    logic [N_OUT-1:0] es;
    logic [N_IN-1:0] nz;
    in_spk = in_v; reward_valid = rv; reward_sign = rs;
    for (int j = 0; j < N_OUT; j++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) s += term(int'(in_v[i*IN_W +: IN_W]), wm[j][i]);
      if (s > ACC_MAX) s = ACC_MAX;
`ifdef SNN_LEAK_EN
      v[j] = pm[j] / 2 + s;
      if (v[j] > ACC_MAX) v[j] = ACC_MAX;
`else
      v[j] = s;
`endif
      es[j] = (v[j] > THRESH);
    end
    best = v[0]; ep = 0;
    for (int j = 1; j < N_OUT; j++) if (v[j] > best) begin best = v[j]; ep = j; end
    if (rv) begin
      for (int j = 0; j < N_OUT; j++)
        for (int i = 0; i < N_IN; i++)
          if (prev_nz[i] && prev_sp[j]) begin
            if (!rs && wm[j][i] < 7) wm[j][i]++;
            if (rs && wm[j][i] > -8) wm[j][i]--;
          end
    end
    for (int i = 0; i < N_IN; i++) nz[i] = (in_v[i*IN_W +: IN_W] != 0);
    for (int j = 0; j < N_OUT; j++) pm[j] = es[j] ? 0 : v[j];
    prev_nz = nz;
    prev_sp = es;
    @(posedge clk); #1;
    check("model_spike", spike, es);
    check("model_pred", prediction, ep);
    reward_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, c;
    tbl[0] = '{ 1, -1, 16'h2222, 2'b11, 0};
    tbl[1] = '{-8, -8, 16'hFFFF, 2'b00, 0};
    tbl[2] = '{ 7,  7, 16'hFFFF, 2'b11, 0};
    tbl[3] = '{ 0,  1, 16'h1111, 2'b11, 1};
    tbl[4] = '{ 0,  0, 16'h0001, 2'b00, 0};
    tbl[5] = '{ 0,  1, 16'h0001, 2'b10, 1};
    tbl[6] = '{-1, -2, 16'h0003, 2'b00, 0};
    tbl[7] = '{-1, -2, 16'h000F, 2'b11, 0};

    rst = 1'b1; write_mode = 1'b0; in_spk = '0; reward_valid = 1'b0; reward_sign = 1'b0;
    set_uniform(1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_spike", spike, 0);
    check("rst_pred", prediction, 0);
    check("rst_ready", ready, 0);
    check("rst_addr", mem_addr, 0);

    rst = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n <= K) check("load_addr", mem_addr, n - 1);
      if (ready) begin lat = n; break; end
    end
    check("reset_to_ready", lat, K + 2);
    model_reset();

    for (int k = 0; k < 8; k++) begin
      set_uniform(tbl[k].w0, tbl[k].w1);
      reload();
      step(tbl[k].in_v, 1'b0, 1'b0);
      check("tbl_spike", spike, tbl[k].sp);
      check("tbl_pred", prediction, tbl[k].pred);
    end

    // Reward sequence: neuron 0 saturated at +7, probe separates 7 from 6 via argmax
    mem_arr[0] = 4'd7;  mem_arr[1] = 4'd2; mem_arr[2] = 4'd0; mem_arr[3] = 4'd0;
    mem_arr[4] = 4'h8;  mem_arr[5] = 4'd5; mem_arr[6] = 4'd0; mem_arr[7] = 4'd0;
    reload();
    step(16'h000F, 1'b0, 1'b0);
    check("rw_fire", spike, 2'b01);
    step(16'h000F, 1'b1, 1'b0);
    step(16'h0031, 1'b0, 1'b0);
    check("rw_sat_pred", prediction, 0);
    step(16'h000F, 1'b0, 1'b0);
    step(16'h000F, 1'b1, 1'b1);
    step(16'h0031, 1'b0, 1'b0);
    check("rw_punish_pred", prediction, 1);
    check("rw_punish_spike", spike, 2'b11);

    // Threshold boundary: sum 1 never fires, sum 2 fires every cycle
    set_uniform(0, 0);
    reload();
    repeat (4) begin
      step(16'h0001, 1'b0, 1'b0);
      check("th_hold", spike, 2'b00);
    end
    repeat (2) begin
      step(16'h0002, 1'b0, 1'b0);
      check("th_fire", spike, 2'b11);
    end

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < K; k++) mem_arr[k] = 4'($urandom_range(0, 15));
      reload();
      repeat (60) step(16'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    // Reset in the middle of a reload
    write_mode = 1'b1;
    @(posedge clk); #1;
    write_mode = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midload_rst_ready", ready, 0);
    check("midload_rst_addr", mem_addr, 0);
    check("midload_rst_spike", spike, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_ready(c);
    check("midload_relatency", c, K + 2);
    model_reset();
    repeat (20) step(16'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
